// File: rtl/cpu_axi4lite_master_bridge.sv
// cpu_axi4lite_master_bridge
// Purpose : Converts a native CPU memory port (valid/ready, byte strobes,
//           instruction flag) into single-outstanding AXI4-lite master
//           transactions, decodes B/R responses and aborts stalled
//           transactions after a programmable number of cycles.
// Latency : 3 cycles from mem_valid to mem_ready against a zero-wait slave,
//           for both reads and writes.
// Backpressure: one transaction outstanding; mem_valid is held by the CPU
//           until mem_ready and is ignored while mem_ready is high or while
//           a timed-out transaction is still draining on the bus.
// Ports   :
//   clk_i, rst_i            clock, asynchronous active-high reset
//   mem_*                   CPU request (valid/instr/addr/wdata/wstrb) and
//                           completion (ready/rdata/err)
//   m_aw*, m_w*, m_b*       AXI4-lite write address, write data, write response
//   m_ar*, m_r*             AXI4-lite read address, read data
module cpu_axi4lite_master_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = '1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // native CPU port
  input  logic                    mem_valid,
  input  logic                    mem_instr,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    mem_ready,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_err,
  // AW channel
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  // W channel
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  // B channel
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  // AR channel
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  // R channel
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("cpu_axi4lite_master_bridge: DATA_WIDTH must be 32 or 64");
  end

  // Timer is wide enough to hold TIMEOUT_CYCLES-1; with the timeout
  // disabled the limit collapses to 0 and the timer never moves.
  localparam int TW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TMAX = TW'(TLIM);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RDATA = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  logic expired;
  logic aw_pend, w_pend, ar_pend;
  logic b_pend, r_pend;
  logic b_err, r_err;

  // SLVERR (10) and DECERR (11) both have bit 1 set.
  function automatic logic is_err(input logic [1:0] resp);
    return (resp == 2'b10) || (resp == 2'b11);
  endfunction

  always_comb begin
    expired = (TIMEOUT_CYCLES != 0) && (timer == TMAX);
    // Channel still pending after this cycle's handshakes.
    aw_pend = m_awvalid & ~m_awready;
    w_pend  = m_wvalid  & ~m_wready;
    ar_pend = m_arvalid & ~m_arready;
    b_pend  = m_bready  & ~m_bvalid;
    r_pend  = m_rready  & ~m_rvalid;
    b_err   = is_err(m_bresp);
    r_err   = is_err(m_rresp);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      timer     <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      m_awprot  <= 3'b000;
      m_wvalid  <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arprot  <= 3'b000;
      m_rready  <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;

      if (state != IDLE && timer != TMAX) begin
        timer <= timer + 1'b1;
      end

      case (state)
        IDLE: begin
          // The request seen alongside mem_ready is the one just completed.
          if (mem_valid && !mem_ready) begin
            timer <= '0;
            if (|mem_wstrb) begin
              m_awaddr  <= mem_addr;
              m_awprot  <= {mem_instr, 2'b00};
              m_wdata   <= mem_wdata;
              m_wstrb   <= mem_wstrb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= WRITE;
            end else begin
              m_araddr  <= mem_addr;
              m_arprot  <= {mem_instr, 2'b00};
              m_arvalid <= 1'b1;
              state     <= READ;
            end
          end
        end

        WRITE: begin
          m_awvalid <= aw_pend;
          m_wvalid  <= w_pend;
          if (!aw_pend && !w_pend) begin
            m_bready <= 1'b1;
            state    <= WRESP;
          end else if (expired) begin
            m_bready  <= 1'b1;
            mem_ready <= 1'b1;
            mem_err   <= 1'b1;
            state     <= DRAIN;
          end
        end

        WRESP: begin
          // A response in the expiry cycle takes priority over the timeout.
          if (m_bvalid) begin
            m_bready  <= 1'b0;
            mem_ready <= 1'b1;
            mem_err   <= b_err;
            state     <= IDLE;
          end else if (expired) begin
            mem_ready <= 1'b1;
            mem_err   <= 1'b1;
            state     <= DRAIN;
          end
        end

        READ: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RDATA;
          end else if (expired) begin
            // rready goes up early so the late R beat is absorbed in DRAIN.
            m_rready  <= 1'b1;
            mem_ready <= 1'b1;
            mem_err   <= 1'b1;
            mem_rdata <= ERR_RDATA;
            state     <= DRAIN;
          end
        end

        RDATA: begin
          if (m_rvalid) begin
            m_rready  <= 1'b0;
            mem_ready <= 1'b1;
            mem_err   <= r_err;
            mem_rdata <= r_err ? ERR_RDATA : m_rdata;
            state     <= IDLE;
          end else if (expired) begin
            mem_ready <= 1'b1;
            mem_err   <= 1'b1;
            mem_rdata <= ERR_RDATA;
            state     <= DRAIN;
          end
        end

        DRAIN: begin
          // Valids cannot be withdrawn before their handshake, so wait for
          // every channel of the abandoned transaction to finish silently.
          m_awvalid <= aw_pend;
          m_wvalid  <= w_pend;
          m_arvalid <= ar_pend;
          m_bready  <= b_pend;
          m_rready  <= r_pend;
          if (!aw_pend && !w_pend && !ar_pend && !b_pend && !r_pend) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi4lite_master_bridge.sv
// tb_cpu_axi4lite_master_bridge
// Purpose : Directed self-checking bench for cpu_axi4lite_master_bridge;
//           a scripted AXI4-lite slave is driven cycle by cycle.
// Ports   : none (top-level bench); DUT built with TIMEOUT_CYCLES=16.
module tb_cpu_axi4lite_master_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_err;
  logic [31:0] mem_rdata;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  int errors = 0;
  int checks = 0;

  cpu_axi4lite_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    idle_inputs();
    tick(); tick();
    checks++;
    if ({mem_ready, mem_err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {mem_ready, mem_err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    checks++;
    if ({mem_rdata, m_awaddr, m_araddr, m_wdata, m_wstrb, m_awprot, m_arprot} !== '0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h awaddr=%h araddr=%h wdata=%h wstrb=%b want all zero",
               mem_rdata, m_awaddr, m_araddr, m_wdata, m_wstrb);
    end
    #2 rst_i = 1'b0;
    tick();
  endtask

  task automatic test_read(input string name, input logic [31:0] addr, input logic instr,
                           input logic [31:0] rd, input logic [1:0] resp,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input logic [2:0] exp_prot);
    mem_valid = 1'b1; mem_instr = instr; mem_addr = addr; mem_wstrb = 4'b0000; mem_wdata = '0;
    m_arready = 1'b1;
    tick(); // cycle 1: AR issued
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== addr || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ar_issue: got arvalid=%b araddr=%h ready=%b want 1 %h 0",
               name, m_arvalid, m_araddr, mem_ready, addr);
    end
    checks++;
    if (m_arprot !== exp_prot) begin
      errors++;
      $display("FAIL %s arprot: got %b want %b", name, m_arprot, exp_prot);
    end
    tick(); // cycle 2: AR done, waiting for R
    checks++;
    if (m_arvalid !== 1'b0 || m_rready !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s r_wait: got arvalid=%b rready=%b ready=%b want 0 1 0",
               name, m_arvalid, m_rready, mem_ready);
    end
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = rd; m_rresp = resp;
    tick(); // cycle 3: completion
    checks++;
    if (mem_ready !== 1'b1 || mem_rdata !== exp_rd || mem_err !== exp_err || m_rready !== 1'b0) begin
      errors++;
      $display("FAIL %s complete: got ready=%b rdata=%h err=%b rready=%b want 1 %h %b 0",
               name, mem_ready, mem_rdata, mem_err, m_rready, exp_rd, exp_err);
    end
    m_rvalid = 1'b0;
    // mem_valid intentionally still high: it must be ignored this cycle.
    tick();
    checks++;
    if (mem_ready !== 1'b0 || m_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s no_reissue: got ready=%b arvalid=%b want 0 0", name, mem_ready, m_arvalid);
    end
    mem_valid = 1'b0;
    tick();
    checks++;
    if (m_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: got arvalid=%b want 0", name, m_arvalid);
    end
  endtask

  // lead = 0: zero-wait slave; lead = 2: wready two cycles before awready.
  task automatic test_write(input string name, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, input int lead, input logic [1:0] resp,
                            input logic exp_err);
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = addr; mem_wdata = wd; mem_wstrb = strb;
    m_wready = 1'b1; m_awready = (lead == 0);
    tick(); // cycle 1
    checks++;
    if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || m_awaddr !== addr || m_wdata !== wd ||
        m_wstrb !== strb || m_awprot !== 3'b000) begin
      errors++;
      $display("FAIL %s w_issue: got awv=%b wv=%b awaddr=%h wdata=%h wstrb=%b prot=%b want 1 1 %h %h %b 000",
               name, m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb, m_awprot, addr, wd, strb);
    end
    if (lead != 0) begin
      tick(); // cycle 2: W done, AW still pending
      checks++;
      if (m_wvalid !== 1'b0 || m_awvalid !== 1'b1 || mem_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s w_first: got wv=%b awv=%b ready=%b want 0 1 0",
                 name, m_wvalid, m_awvalid, mem_ready);
      end
      m_wready = 1'b0;
      tick(); // cycle 3
      checks++;
      if (m_awvalid !== 1'b1 || m_bready !== 1'b0 || m_wvalid !== 1'b0) begin
        errors++;
        $display("FAIL %s aw_hold: got awv=%b bready=%b wv=%b want 1 0 0",
                 name, m_awvalid, m_bready, m_wvalid);
      end
      m_awready = 1'b1;
    end
    tick();
    checks++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_bready !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s b_wait: got awv=%b wv=%b bready=%b ready=%b want 0 0 1 0",
               name, m_awvalid, m_wvalid, m_bready, mem_ready);
    end
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b1; m_bresp = resp;
    tick();
    checks++;
    if (mem_ready !== 1'b1 || mem_err !== exp_err) begin
      errors++;
      $display("FAIL %s complete: got ready=%b err=%b want 1 %b", name, mem_ready, mem_err, exp_err);
    end
    m_bvalid = 1'b0; mem_valid = 1'b0;
    tick();
    checks++;
    if (mem_ready !== 1'b0 || m_bready !== 1'b0) begin
      errors++;
      $display("FAIL %s single_pulse: got ready=%b bready=%b want 0 0", name, mem_ready, m_bready);
    end
  endtask

  task automatic test_timeout;
    int  k;
    bit  got;
    bit  ar_dropped;
    bit  bad_accept;
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0000_3000; mem_wstrb = 4'b0000;
    m_arready = 1'b0;
    tick(); // issue cycle
    checks++;
    if (m_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL to_issue: got arvalid=%b want 1", m_arvalid);
    end
    k = 0; got = 1'b0; ar_dropped = 1'b0;
    while (k < 40 && !got) begin
      tick();
      k++;
      if (mem_ready === 1'b1) got = 1'b1;
      else if (m_arvalid !== 1'b1) ar_dropped = 1'b1;
    end
    checks++;
    if (!got || k != 16) begin
      errors++;
      $display("FAIL to_latency: got ready=%b after %0d cycles want 1 after 16", got, k);
    end
    checks++;
    if (mem_err !== 1'b1 || mem_rdata !== 32'hFFFF_FFFF || m_arvalid !== 1'b1 || ar_dropped) begin
      errors++;
      $display("FAIL to_err: got err=%b rdata=%h arvalid=%b dropped=%b want 1 ffffffff 1 0",
               mem_err, mem_rdata, m_arvalid, ar_dropped);
    end
    mem_valid = 1'b0;
    tick();
    mem_valid = 1'b1; mem_addr = 32'h0000_4000; mem_wdata = 32'h0000_AA55; mem_wstrb = 4'b1111;
    bad_accept = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m_awvalid !== 1'b0 || m_arvalid !== 1'b1 || mem_ready !== 1'b0) bad_accept = 1'b1;
    end
    checks++;
    if (bad_accept) begin
      errors++;
      $display("FAIL to_drain_block: got request accepted or arvalid dropped, want held off");
    end
    m_arready = 1'b1;
    tick();
    checks++;
    if (m_arvalid !== 1'b0 || m_rready !== 1'b1 || m_awvalid !== 1'b0) begin
      errors++;
      $display("FAIL to_drain_ar: got arvalid=%b rready=%b awvalid=%b want 0 1 0",
               m_arvalid, m_rready, m_awvalid);
    end
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1111_1111; m_rresp = 2'b00;
    tick();
    checks++;
    if (mem_ready !== 1'b0 || m_rready !== 1'b0 || m_awvalid !== 1'b0) begin
      errors++;
      $display("FAIL to_drain_r: got ready=%b rready=%b awvalid=%b want 0 0 0",
               mem_ready, m_rready, m_awvalid);
    end
    m_rvalid = 1'b0;
    tick();
    checks++;
    if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || m_awaddr !== 32'h0000_4000) begin
      errors++;
      $display("FAIL to_next_req: got awv=%b wv=%b awaddr=%h want 1 1 00004000",
               m_awvalid, m_wvalid, m_awaddr);
    end
    m_awready = 1'b1; m_wready = 1'b1;
    tick();
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00;
    tick();
    checks++;
    if (mem_ready !== 1'b1 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL to_next_done: got ready=%b err=%b want 1 0", mem_ready, mem_err);
    end
    m_bvalid = 1'b0; mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    bit pulsed;
    mem_valid = 1'b1; mem_addr = 32'h0000_5000; mem_wdata = 32'h0BAD_F00D; mem_wstrb = 4'b1111;
    m_awready = 1'b0; m_wready = 1'b0;
    tick();
    checks++;
    if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got awv=%b wv=%b want 1 1", m_awvalid, m_wvalid);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got awv=%b wv=%b ready=%b want 0 0 0",
               m_awvalid, m_wvalid, mem_ready);
    end
    mem_valid = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (mem_ready !== 1'b0) pulsed = 1'b1;
    end
    #2 rst_i = 1'b0;
    tick();
    if (mem_ready !== 1'b0) pulsed = 1'b1;
    checks++;
    if (pulsed) begin
      errors++;
      $display("FAIL rst_mid_nopulse: got mem_ready pulse want none");
    end
  endtask

  initial begin
    test_reset();
    test_read("rd_ok", 32'h0000_1000, 1'b0, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 1'b0, 3'b000);
    test_read("ifetch", 32'h0000_0100, 1'b1, 32'h0000_0013, 2'b00, 32'h0000_0013, 1'b0, 3'b100);
    test_write("wr_split", 32'h0000_2000, 32'h1234_5678, 4'b0011, 2, 2'b00, 1'b0);
    test_read("rd_decerr", 32'h0000_1004, 1'b0, 32'h1234_5678, 2'b11, 32'hFFFF_FFFF, 1'b1, 3'b000);
    test_write("wr_slverr", 32'h0000_2004, 32'hDEAD_BEEF, 4'b1111, 0, 2'b10, 1'b1);
    test_timeout();
    test_reset_mid();
    test_read("rd_post_rst", 32'h0000_6000, 1'b0, 32'h5A5A_A5A5, 2'b00, 32'h5A5A_A5A5, 1'b0, 3'b000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
